// File: rtl/add_not_unit_32_if.sv
// Operand/result bundle for the add/invert/negate ALU slice.
// The master side issues operations; the slave side (the unit) returns registered results.
interface add_not_unit_32_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic [1:0]       op;
    logic [WIDTH-1:0] Ra;
    logic [WIDTH-1:0] Rb;
    logic             cin;
    logic [WIDTH-1:0] Rz;
    logic             cout;
    logic             out_valid;
    logic             ovf;

    modport master (
        output in_valid, op, Ra, Rb, cin,
        input  Rz, cout, out_valid, ovf
    );

    modport slave (
        input  in_valid, op, Ra, Rb, cin,
        output Rz, cout, out_valid, ovf
    );
endinterface

// File: rtl/add_not_unit_32.sv
// Registered ADD/NOT/NEG/SUB slice built around one shared carry-lookahead adder.
// Optional macro ADDNOT_OVERFLOW_EN registers signed overflow on ovf; otherwise ovf is tied to 0.
module add_not_unit_32 #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               clr,
    add_not_unit_32_if.slave   bus
);

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_NOT = 2'b01,
        OP_NEG = 2'b10,
        OP_SUB = 2'b11
    } op_e;

    // 4-bit lookahead groups; the group carry ripples into the next group.
    function automatic logic [WIDTH:0] cla_add(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic             ci
    );
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
        logic [WIDTH:0]   carry;
        g        = a & b;
        p        = a ^ b;
        carry    = '0;
        carry[0] = ci;
        for (int grp = 0; grp < WIDTH / 4; grp++) begin
            carry[grp*4+1] = g[grp*4] | (p[grp*4] & carry[grp*4]);
            carry[grp*4+2] = g[grp*4+1] | (p[grp*4+1] & g[grp*4])
                           | (p[grp*4+1] & p[grp*4] & carry[grp*4]);
            carry[grp*4+3] = g[grp*4+2] | (p[grp*4+2] & g[grp*4+1])
                           | (p[grp*4+2] & p[grp*4+1] & g[grp*4])
                           | (p[grp*4+2] & p[grp*4+1] & p[grp*4] & carry[grp*4]);
            carry[grp*4+4] = g[grp*4+3] | (p[grp*4+3] & g[grp*4+2])
                           | (p[grp*4+3] & p[grp*4+2] & g[grp*4+1])
                           | (p[grp*4+3] & p[grp*4+2] & p[grp*4+1] & g[grp*4])
                           | (p[grp*4+3] & p[grp*4+2] & p[grp*4+1] & p[grp*4] & carry[grp*4]);
        end
        return {carry[WIDTH], p ^ carry[WIDTH-1:0]};
    endfunction

    logic [WIDTH-1:0] x_p0;
    logic [WIDTH-1:0] y_p0;
    logic             c_p0;
    logic [WIDTH:0]   sum_p0;
    logic [WIDTH-1:0] rz_p0;
    logic             cout_p0;
    logic             ovf_p0;

    logic [WIDTH-1:0] rz_p1;
    logic             cout_p1;
    logic             vld_p1;

    // ---- stage p0: operand steering, shared adder, result select ----
    always_comb begin
        x_p0 = bus.Ra;
        y_p0 = bus.Rb;
        c_p0 = bus.cin;
        unique case (op_e'(bus.op))
            OP_ADD: begin x_p0 = bus.Ra;  y_p0 = bus.Rb;  c_p0 = bus.cin; end
            OP_NOT: begin x_p0 = bus.Ra;  y_p0 = bus.Rb;  c_p0 = 1'b0;    end
            OP_NEG: begin x_p0 = ~bus.Ra; y_p0 = '0;      c_p0 = 1'b1;    end
            OP_SUB: begin x_p0 = bus.Ra;  y_p0 = ~bus.Rb; c_p0 = 1'b1;    end
            default: ;
        endcase
    end

    assign sum_p0 = cla_add(x_p0, y_p0, c_p0);

    always_comb begin
        rz_p0   = sum_p0[WIDTH-1:0];
        cout_p0 = sum_p0[WIDTH];
        ovf_p0  = (x_p0[WIDTH-1] == y_p0[WIDTH-1]) && (sum_p0[WIDTH-1] != x_p0[WIDTH-1]);
        if (op_e'(bus.op) == OP_NOT) begin
            rz_p0   = ~bus.Ra;
            cout_p0 = 1'b0;
            ovf_p0  = 1'b0;
        end
    end

    // ---- stage p1: result registers, held while no operation is accepted ----
    always_ff @(posedge clk) begin
        if (clr) begin
            vld_p1  <= 1'b0;
            rz_p1   <= '0;
            cout_p1 <= 1'b0;
        end else begin
            vld_p1 <= bus.in_valid;
            if (bus.in_valid) begin
                rz_p1   <= rz_p0;
                cout_p1 <= cout_p0;
            end
        end
    end

`ifdef ADDNOT_OVERFLOW_EN
    logic ovf_p1;

    always_ff @(posedge clk) begin
        if (clr) begin
            ovf_p1 <= 1'b0;
        end else if (bus.in_valid) begin
            ovf_p1 <= ovf_p0;
        end
    end

    assign bus.ovf = ovf_p1;
`else
    logic unused_ovf_p0;
    assign unused_ovf_p0 = ovf_p0;
    assign bus.ovf       = 1'b0;
`endif

    assign bus.Rz        = rz_p1;
    assign bus.cout      = cout_p1;
    assign bus.out_valid = vld_p1;

endmodule

// File: tb/tb_add_not_unit_32.sv
// Randomised and directed bench for add_not_unit_32 against a plain-arithmetic reference model.
module tb_add_not_unit_32;

    logic clk = 1'b0;
    logic clr = 1'b0;
    int   n_chk = 0;
    int   n_bad = 0;

    logic [31:0] exp_rz   = '0;
    logic        exp_cout = 1'b0;
    logic        exp_ovf  = 1'b0;
    logic        exp_vld  = 1'b0;

    add_not_unit_32_if #(.WIDTH(32)) bus ();

    add_not_unit_32 #(.WIDTH(32)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %08h, expected %08h", tag, got, want);
        end
    endtask

    // Reference result from mathematical definitions of each operation.
    task automatic ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic ci, output logic [31:0] r, output logic co, output logic ov);
        longint sa, sb, sres;
        logic [32:0] wide;
        sa   = $signed(a);
        sb   = $signed(b);
        sres = 0;
        r    = '0;
        co   = 1'b0;
        case (op)
            2'b00: begin
                wide = {1'b0, a} + {1'b0, b} + {32'b0, ci};
                r    = wide[31:0];
                co   = wide[32];
                sres = sa + sb + (ci ? 64'sd1 : 64'sd0);
            end
            2'b01: begin r = ~a; co = 1'b0; sres = 0; end
            2'b10: begin r = 32'd0 - a; co = (a == 32'd0); sres = -sa; end
            default: begin r = a - b; co = (a >= b); sres = sa - sb; end
        endcase
`ifdef ADDNOT_OVERFLOW_EN
        ov = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
`else
        ov = 1'b0;
`endif
    endtask

    // One clock: drive at negedge, update model at the edge, compare just after it.
    task automatic step(input logic c, input logic v, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b, input logic ci);
        logic [31:0] r;
        logic co, ov;
        @(negedge clk);
        clr          = c;
        bus.in_valid = v;
        bus.op       = op;
        bus.Ra       = a;
        bus.Rb       = b;
        bus.cin      = ci;
        ref_op(op, a, b, ci, r, co, ov);
        @(posedge clk);
        if (c) begin
            exp_rz = '0; exp_cout = 1'b0; exp_ovf = 1'b0; exp_vld = 1'b0;
        end else begin
            exp_vld = v;
            if (v) begin exp_rz = r; exp_cout = co; exp_ovf = ov; end
        end
        #1;
        check("rz",        bus.Rz,                 exp_rz);
        check("cout",      {31'b0, bus.cout},      {31'b0, exp_cout});
        check("ovf",       {31'b0, bus.ovf},       {31'b0, exp_ovf});
        check("out_valid", {31'b0, bus.out_valid}, {31'b0, exp_vld});
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0: v = 32'h0000_0000;
            1: v = 32'hFFFF_FFFF;
            2: v = 32'h8000_0000;
            3: v = 32'h7FFF_FFFF;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        logic ovf_want;
        bus.in_valid = 1'b0;
        bus.op       = 2'b00;
        bus.Ra       = '0;
        bus.Rb       = '0;
        bus.cin      = 1'b0;

        // reset with in_valid high for two cycles
        step(1'b1, 1'b1, 2'b00, 32'h1234_5678, 32'h1, 1'b1);
        step(1'b1, 1'b1, 2'b11, 32'hFFFF_FFFF, 32'h2, 1'b0);
        check("rst_rz", bus.Rz, 32'h0);

        // operation dropped by clr, then idle
        step(1'b1, 1'b1, 2'b00, 32'h5, 32'h6, 1'b0);
        step(1'b0, 1'b0, 2'b00, 32'h5, 32'h6, 1'b0);
        check("drop_rz",  bus.Rz, 32'h0);
        check("drop_vld", {31'b0, bus.out_valid}, 32'h0);

        // back-to-back NEG
        step(1'b0, 1'b1, 2'b10, 32'h0000_0000, 32'h0, 1'b0);
        check("neg0_rz", bus.Rz, 32'h0000_0000);
        check("neg0_co", {31'b0, bus.cout}, 32'h1);
        step(1'b0, 1'b1, 2'b10, 32'hAAAA_AAAA, 32'h0, 1'b1);
        check("negA_rz", bus.Rz, 32'h5555_5556);
        check("negA_co", {31'b0, bus.cout}, 32'h0);
        step(1'b0, 1'b1, 2'b10, 32'hFFFF_FFFF, 32'h0, 1'b0);
        check("negF_rz", bus.Rz, 32'h0000_0001);
        check("negF_vld", {31'b0, bus.out_valid}, 32'h1);

        step(1'b0, 1'b1, 2'b01, 32'hAAAA_AAAA, 32'h1, 1'b1);
        check("notA_rz", bus.Rz, 32'h5555_5555);
        step(1'b0, 1'b1, 2'b01, 32'h0000_0000, 32'h1, 1'b0);
        check("not0_rz", bus.Rz, 32'hFFFF_FFFF);

        step(1'b0, 1'b1, 2'b00, 32'hFFFF_FFFF, 32'h1, 1'b0);
        check("addwrap_rz", bus.Rz, 32'h0);
        check("addwrap_co", {31'b0, bus.cout}, 32'h1);
        step(1'b0, 1'b1, 2'b00, 32'h7FFF_FFFF, 32'h0, 1'b1);
        check("addovf_rz", bus.Rz, 32'h8000_0000);
`ifdef ADDNOT_OVERFLOW_EN
        ovf_want = 1'b1;
`else
        ovf_want = 1'b0;
`endif
        check("addovf_ovf", {31'b0, bus.ovf}, {31'b0, ovf_want});

        step(1'b0, 1'b1, 2'b10, 32'h8000_0000, 32'h0, 1'b0);
        check("negmin_ovf", {31'b0, bus.ovf}, {31'b0, ovf_want});

        step(1'b0, 1'b1, 2'b11, 32'h5, 32'h7, 1'b0);
        check("sub57_rz", bus.Rz, 32'hFFFF_FFFE);
        check("sub57_co", {31'b0, bus.cout}, 32'h0);
        step(1'b0, 1'b1, 2'b11, 32'h7, 32'h5, 1'b0);
        check("sub75_rz", bus.Rz, 32'h0000_0002);
        check("sub75_co", {31'b0, bus.cout}, 32'h1);

        // idle gap with changing operands: result holds
        step(1'b0, 1'b0, 2'b00, 32'hDEAD_BEEF, 32'h1, 1'b1);
        step(1'b0, 1'b0, 2'b10, 32'h1234_0000, 32'h9, 1'b0);
        check("hold_rz", bus.Rz, 32'h0000_0002);

        // random traffic with occasional clr and idle cycles
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
                 2'($urandom_range(0, 3)), pick(), pick(), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/add_not_unit_32.md
Name: add_not_unit_32

Overview:
- Registered 32-bit arithmetic/logic unit combining a bitwise inverter with a 32-bit carry adder.
- Performs ADD, NOT, NEGATE (two's complement) and SUB.
- Used as the add/invert/negate datapath slice of the CPU ALU.
- One-cycle latency with a valid handshake; result held until the next accepted operation.

Parameters:
- WIDTH, 32, operand/result width; the block is verified only at 32.

Ports:
- clk  input  1  rising-edge clock
- clr  input  1  synchronous active-high reset
- in_valid  input  1  operands/op accepted on the clk edge when high
- op  input  2  operation select: 00 ADD, 01 NOT, 10 NEG, 11 SUB
- Ra  input  32  operand A
- Rb  input  32  operand B (used by ADD/SUB only)
- cin  input  1  carry-in (used by ADD only)
- Rz  output  32  registered result
- cout  output  1  registered carry-out of bit 31
- out_valid  output  1  high for one cycle after each accepted operation
- ovf  output  1  registered signed overflow (see Optional Feature)

Behaviour:
- Interface: one clock (clk); synchronous active-high reset (clr). No asynchronous paths.
- Reset: on a clk edge with clr=1, Rz=0, cout=0, ovf=0, out_valid=0. clr has priority over in_valid.
- Reset mid-operation: an operation presented in the same cycle as clr is dropped, and no out_valid follows.
- Capture: on a clk edge with clr=0 and in_valid=1, compute from the current inputs and register the result.
  - Latency is exactly 1 cycle; out_valid=1 in the following cycle.
- Hold: with in_valid=0, out_valid drops to 0 and Rz/cout/ovf hold their last values.
- Back-to-back: in_valid may be high every cycle; throughput is 1 operation per cycle.
- Datapath: one shared 32-bit adder computing S = X + Y + c. Inverter output is ~Ra.
  - ADD: X=Ra, Y=Rb, c=cin. Rz=S[31:0], cout=carry out of bit 31.
  - NOT: Rz=~Ra, cout=0.
  - NEG: X=~Ra, Y=0, c=1 (equivalent to ~Ra + 1). Rz=-Ra mod 2^32. cout=1 only when Ra=0.
  - SUB: X=Ra, Y=~Rb, c=1. Rz=Ra-Rb mod 2^32. cout=1 when Ra>=Rb unsigned (no borrow).
- cin is ignored for NOT/NEG/SUB; Rb is ignored for NOT/NEG.
- Arithmetic wraps modulo 2^32; no saturation.
- Adder structure: 4-bit carry-lookahead groups chained by ripple between groups. The combinational path must fit one clock period.

Optional Feature:
- Macro: ADDNOT_OVERFLOW_EN.
- Defined: ovf registers signed two's-complement overflow.
  - ADD/SUB/NEG: ovf = (X[31]==Y[31]) && (S[31]!=X[31]).
  - NOT: ovf=0.
  - Examples: NEG of 32'h80000000 gives ovf=1; ADD 7FFFFFFF+1 gives ovf=1.
- Not defined: ovf is tied to constant 0. The port remains present so instantiations are unchanged.

Test Plan:
- clr=1 for 2 cycles with in_valid=1 -> Rz=0, cout=0, ovf=0, out_valid=0 throughout.
- NEG with Ra=00000000, then AAAAAAAA, then FFFFFFFF, back-to-back -> out_valid high for 3 consecutive cycles with:
  - Rz=00000000 (cout=1)
  - Rz=55555556 (cout=0)
  - Rz=00000001 (cout=0)
- NOT with Ra=AAAAAAAA -> Rz=55555555, cout=0. NOT with Ra=00000000 -> Rz=FFFFFFFF.
- ADD with Ra=FFFFFFFF, Rb=00000001, cin=0 -> Rz=00000000, cout=1.
  - ADD with Ra=7FFFFFFF, Rb=0, cin=1 -> Rz=80000000, cout=0; ovf=1 if ADDNOT_OVERFLOW_EN is defined, else 0.
- SUB with Ra=5, Rb=7 -> Rz=FFFFFFFE, cout=0. SUB with Ra=7, Rb=5 -> Rz=00000002, cout=1.
- ADD issued with clr asserted the same cycle, then in_valid=0 -> out_valid stays 0 and Rz stays 0.
  - A later in_valid=0 gap after a valid result -> Rz holds, out_valid=0.
